// File: rtl/reg_file_64.sv
// 32 x 64-bit register file, one write port and two combinational read ports; x0 reads zero.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to a matching read port.
module reg_file_64 (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [4:0]  wr_idx,
  input  logic [63:0] wr_data,
  input  logic [4:0]  rd1_idx,
  input  logic [4:0]  rd2_idx,
  output logic [63:0] rd1_data,
  output logic [63:0] rd2_data
);

  logic [63:0] regs_q [32];
  logic        wr_go;

  // An unknown wr_en never satisfies the condition, so state is left untouched.
  assign wr_go = wr_en && (wr_idx != 5'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_go) begin
      regs_q[wr_idx] <= wr_data;
    end
  end

  always_comb begin
    rd1_data = '0;
    rd2_data = '0;
    if (!reset && (rd1_idx != 5'd0)) begin
      rd1_data = regs_q[rd1_idx];
    end
    if (!reset && (rd2_idx != 5'd0)) begin
      rd2_data = regs_q[rd2_idx];
    end
`ifdef REGFILE_BYPASS_EN
    // wr_go already excludes index 0, so x0 is never forwarded.
    if (!reset && wr_go && (rd1_idx == wr_idx)) begin
      rd1_data = wr_data;
    end
    if (!reset && wr_go && (rd2_idx == wr_idx)) begin
      rd2_data = wr_data;
    end
`endif
  end

endmodule

// File: tb/tb_reg_file_64.sv
// Randomized self-checking bench for reg_file_64 against an array-based reference model.
module tb_reg_file_64;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_idx;
  logic [63:0] wr_data;
  logic [4:0]  rd1_idx;
  logic [4:0]  rd2_idx;
  logic [63:0] rd1_data;
  logic [63:0] rd2_data;

  int checks;
  int failures;

  logic [63:0] model [32];

  reg_file_64 dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_data  (wr_data),
    .rd1_idx  (rd1_idx),
    .rd2_idx  (rd2_idx),
    .rd1_data (rd1_data),
    .rd2_data (rd2_data)
  );

  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: array of registers, x0 never written.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) model[i] <= '0;
    end else if (wr_en === 1'b1 && wr_idx != 5'd0) begin
      model[wr_idx] <= wr_data;
    end
  end

  function automatic logic [63:0] expect_rd(input logic [4:0] idx);
    if (reset || idx == 5'd0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en === 1'b1 && wr_idx == idx) return wr_data;
`endif
    return model[idx];
  endfunction

  always @(negedge clk) begin
    check("cmp_rd1", rd1_data, expect_rd(rd1_idx));
    check("cmp_rd2", rd2_data, expect_rd(rd2_idx));
  end

  task automatic write(input logic [4:0] idx, input logic [63:0] data);
    wr_en   = 1'b1;
    wr_idx  = idx;
    wr_data = data;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  initial begin
    logic [63:0] pat;
    logic [4:0]  j;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    wr_en    = 1'b0;
    wr_idx   = '0;
    wr_data  = '0;
    rd1_idx  = 5'd1;
    rd2_idx  = 5'd31;

    // Write coincident with reset is lost.
    wr_en   = 1'b1;
    wr_idx  = 5'd5;
    wr_data = 64'hDEAD;
    repeat (2) @(posedge clk);
    #1;
    wr_en = 1'b0;
    reset = 1'b0;
    rd1_idx = 5'd5;
    #1;
    check("reset_state_x5", rd1_data, 64'h0);
    check("reset_state_x31", rd2_data, 64'h0);

    // Basic write/read.
    write(5'd1, 64'd5);
    write(5'd2, 64'd10);
    rd1_idx = 5'd1;
    rd2_idx = 5'd2;
    #1;
    check("basic_x1", rd1_data, 64'd5);
    check("basic_x2", rd2_data, 64'd10);

    // x0 discards writes.
    write(5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    rd1_idx = 5'd0;
    #1;
    check("x0_zero", rd1_data, 64'h0);

    // wr_en=0 holds state.
    write(5'd3, 64'd1);
    wr_en   = 1'b0;
    wr_idx  = 5'd3;
    wr_data = 64'd7;
    @(posedge clk);
    #1;
    rd1_idx = 5'd3;
    #1;
    check("wr_en_low_hold", rd1_data, 64'd1);

    // Same-cycle read/write of x4.
    write(5'd4, 64'd1);
    wr_en   = 1'b1;
    wr_idx  = 5'd4;
    wr_data = 64'd9;
    rd1_idx = 5'd4;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("rdw_before_edge", rd1_data, 64'd9);
`else
    check("rdw_before_edge", rd1_data, 64'd1);
`endif
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    #1;
    check("rdw_after_edge", rd1_data, 64'd9);

    // Full width, all indices, no aliasing.
    for (int i = 1; i < 32; i++) write(5'(i), {32'hA5A5A5A5, 32'(i)});
    for (int i = 0; i < 32; i++) begin
      j = 5'((i * 7 + 3) % 32);
      rd1_idx = 5'(i);
      rd2_idx = j;
      #1;
      pat = (i == 0) ? 64'h0 : {32'hA5A5A5A5, 32'(i)};
      check("pattern_rd1", rd1_data, pat);
      pat = (j == 5'd0) ? 64'h0 : {32'hA5A5A5A5, 27'd0, j};
      check("pattern_rd2", rd2_data, pat);
    end

    // Randomized traffic, checked every cycle by the compare process.
    for (int n = 0; n < 2000; n++) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 15) == 0) wr_en = 1'bx;
      else wr_en = 1'($urandom_range(0, 1));
      wr_idx  = 5'($urandom_range(0, 31));
      wr_data = {$urandom, $urandom};
      rd1_idx = ($urandom_range(0, 3) == 0) ? wr_idx : 5'($urandom_range(0, 31));
      rd2_idx = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 99) == 0) begin
        #10 reset = 1'b1;
        #10 reset = 1'b0;
      end
    end

    // Mid-run asynchronous reset after populating x1..x31.
    for (int i = 1; i < 32; i++) write(5'(i), {$urandom, $urandom} | 64'h1);
    #10;
    reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rd1_idx = 5'(i);
      rd2_idx = 5'(31 - i);
      #1;
      check("async_reset_rd1", rd1_data, 64'h0);
      check("async_reset_rd2", rd2_data, 64'h0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    rd1_idx = 5'd17;
    #1;
    check("after_reset_x17", rd1_data, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
